// File: rtl/prescaled_counter_bank.sv
// Bank of NCH event counters, each with its own prescaler, wrap/saturate mode,
// sticky overflow flag, and a shared single-cycle read port with clear-on-read.
module prescaled_counter_bank #(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 32,
  parameter  int PW    = 4,
  localparam int CW    = (NCH < 2) ? 1 : $clog2(NCH)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   En,
  input  logic [CW-1:0]          Sel,
  input  logic                   CfgWe,
  input  logic [CW-1:0]          CfgCh,
  input  logic [PW-1:0]          CfgDiv,
  input  logic                   CfgMode,
  input  logic [NCH-1:0]         ClrMask,
  input  logic                   RdReq,
  input  logic [CW-1:0]          RdCh,
  input  logic                   RdClr,
  output logic [NCH*WIDTH-1:0]   Count,
  output logic [NCH-1:0]         Ovf,
  output logic                   AnyOvf,
  output logic                   RdValid,
  output logic [WIDTH-1:0]       RdData
);

  logic [NCH-1:0][WIDTH-1:0] count_bus;
  logic [NCH-1:0]            ovf_bus;

  logic                      rd_valid_reg;
  logic [WIDTH-1:0]          rd_data_reg;
  logic [WIDTH-1:0]          rd_data_next;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [CW-1:0] CH_ID = CW'(gi);

      logic [WIDTH-1:0] count_reg, count_next;
      logic [PW-1:0]    pre_reg, pre_next;
      logic [PW-1:0]    div_reg, div_next;
      logic             mode_reg, mode_next;
      logic             ovf_reg, ovf_next;

      logic evt_hit, cfg_hit, clr_hit, bump;

      // Matching against a fixed in-range id makes out-of-range selects inert.
      assign evt_hit = En && (Sel == CH_ID);
      assign cfg_hit = CfgWe && (CfgCh == CH_ID);
      assign clr_hit = ClrMask[gi] || (RdReq && RdClr && (RdCh == CH_ID));
      assign bump    = (pre_reg == div_reg);

      always_comb begin
        count_next = count_reg;
        pre_next   = pre_reg;
        div_next   = div_reg;
        mode_next  = mode_reg;
        ovf_next   = ovf_reg;
        if (clr_hit) begin
          count_next = '0;
          pre_next   = '0;
          ovf_next   = 1'b0;
        end else if (cfg_hit) begin
          div_next   = CfgDiv;
          mode_next  = CfgMode;
          pre_next   = '0;
        end else if (evt_hit) begin
          if (bump) begin
            pre_next = '0;
            if (&count_reg) begin
              ovf_next = 1'b1;
              if (!mode_reg)
                count_next = '0;
            end else begin
              count_next = count_reg + WIDTH'(1);
            end
          end else begin
            pre_next = pre_reg + PW'(1);
          end
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          count_reg <= '0;
          pre_reg   <= '0;
          div_reg   <= '0;
          mode_reg  <= 1'b0;
          ovf_reg   <= 1'b0;
        end else begin
          count_reg <= count_next;
          pre_reg   <= pre_next;
          div_reg   <= div_next;
          mode_reg  <= mode_next;
          ovf_reg   <= ovf_next;
        end
      end

      assign count_bus[gi] = count_reg;
      assign ovf_bus[gi]   = ovf_reg;
    end
  endgenerate

  // Read mux; an unmatched channel index yields zero.
  always_comb begin
    rd_data_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (RdCh == CW'(i))
        rd_data_next = count_bus[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= RdReq;
      if (RdReq)
        rd_data_reg <= rd_data_next;
    end
  end

  assign Count   = count_bus;
  assign Ovf     = ovf_bus;
  assign AnyOvf  = |ovf_bus;
  assign RdValid = rd_valid_reg;
  assign RdData  = rd_data_reg;

endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Directed bench for prescaled_counter_bank with NCH=6, WIDTH=4 so that
// out-of-range channel indices and 4-bit overflow are both reachable.
module tb_prescaled_counter_bank;
  localparam int NCH   = 6;
  localparam int WIDTH = 4;
  localparam int PW    = 4;
  localparam int CW    = 3;

  logic                 Clk = 1'b0;
  logic                 Reset, En, CfgWe, CfgMode, RdReq, RdClr;
  logic [CW-1:0]        Sel, CfgCh, RdCh;
  logic [PW-1:0]        CfgDiv;
  logic [NCH-1:0]       ClrMask;
  logic [NCH*WIDTH-1:0] Count;
  logic [NCH-1:0]       Ovf;
  logic                 AnyOvf, RdValid;
  logic [WIDTH-1:0]     RdData;

  int n_cmp = 0;
  int n_bad = 0;

  prescaled_counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .PW(PW)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel),
    .CfgWe(CfgWe), .CfgCh(CfgCh), .CfgDiv(CfgDiv), .CfgMode(CfgMode),
    .ClrMask(ClrMask), .RdReq(RdReq), .RdCh(RdCh), .RdClr(RdClr),
    .Count(Count), .Ovf(Ovf), .AnyOvf(AnyOvf),
    .RdValid(RdValid), .RdData(RdData)
  );

  always #5 Clk = ~Clk;

  function automatic logic [WIDTH-1:0] cnt(input int ch);
    return Count[ch*WIDTH +: WIDTH];
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic events(input int ch, input int n);
    En  = 1'b1;
    Sel = CW'(ch);
    for (int k = 0; k < n; k++) tick();
    En  = 1'b0;
  endtask

  task automatic cfg(input int ch, input int dv, input logic md);
    CfgWe = 1'b1; CfgCh = CW'(ch); CfgDiv = PW'(dv); CfgMode = md;
    tick();
    CfgWe = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    n_cmp++; if (Count !== '0) begin n_bad++; $display("FAIL reset_count: got %h want 0", Count); end
    n_cmp++; if (Ovf !== '0 || AnyOvf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b/%b want 0/0", Ovf, AnyOvf); end
    n_cmp++; if (RdValid !== 1'b0 || RdData !== '0) begin n_bad++; $display("FAIL reset_rd: got %b/%h want 0/0", RdValid, RdData); end
    $display("test_reset done");
  endtask

  task automatic test_basic_count;
    events(0, 5);
    n_cmp++; if (Count !== 24'h000005) begin n_bad++; $display("FAIL basic_count: got %h want 000005", Count); end
    n_cmp++; if (Ovf !== '0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", Ovf); end
    events(6, 3);
    events(7, 2);
    n_cmp++; if (Count !== 24'h000005) begin n_bad++; $display("FAIL sel_out_of_range: got %h want 000005", Count); end
    $display("test_basic_count done");
  endtask

  task automatic test_prescale;
    logic [WIDTH-1:0] exp;
    cfg(1, 3, 1'b0);
    En = 1'b1; Sel = 3'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k >= 8) ? 4'd2 : (k >= 4) ? 4'd1 : 4'd0;
      n_cmp++; if (cnt(1) !== exp) begin n_bad++; $display("FAIL prescale_ev%0d: got %0d want %0d", k, cnt(1), exp); end
    end
    En = 1'b0;
    $display("test_prescale done");
  endtask

  task automatic test_overflow;
    cfg(2, 0, 1'b0);
    cfg(3, 0, 1'b1);
    events(2, 16);
    n_cmp++; if (cnt(2) !== 4'd0 || Ovf[2] !== 1'b1) begin n_bad++; $display("FAIL wrap16: got %0d/%b want 0/1", cnt(2), Ovf[2]); end
    events(2, 1);
    n_cmp++; if (cnt(2) !== 4'd1 || Ovf[2] !== 1'b1) begin n_bad++; $display("FAIL wrap17: got %0d/%b want 1/1", cnt(2), Ovf[2]); end
    events(3, 17);
    n_cmp++; if (cnt(3) !== 4'd15 || Ovf[3] !== 1'b1) begin n_bad++; $display("FAIL sat17: got %0d/%b want 15/1", cnt(3), Ovf[3]); end
    n_cmp++; if (Ovf !== 6'b001100 || AnyOvf !== 1'b1) begin n_bad++; $display("FAIL ovf_vec: got %b/%b want 001100/1", Ovf, AnyOvf); end
    ClrMask = 6'b001100;
    tick();
    ClrMask = '0;
    n_cmp++; if (cnt(2) !== 4'd0 || cnt(3) !== 4'd0 || Ovf !== '0 || AnyOvf !== 1'b0) begin
      n_bad++; $display("FAIL clrmask: got c2=%0d c3=%0d ovf=%b any=%b want 0 0 0 0", cnt(2), cnt(3), Ovf, AnyOvf);
    end
    events(3, 16);
    n_cmp++; if (cnt(3) !== 4'd15 || Ovf[3] !== 1'b1) begin n_bad++; $display("FAIL mode_kept: got %0d/%b want 15/1", cnt(3), Ovf[3]); end
    $display("test_overflow done");
  endtask

  task automatic test_clr_priority;
    events(0, 2);
    n_cmp++; if (cnt(0) !== 4'd7) begin n_bad++; $display("FAIL pre_clr: got %0d want 7", cnt(0)); end
    ClrMask = 6'b000001; En = 1'b1; Sel = 3'd0;
    tick();
    ClrMask = '0; En = 1'b0;
    n_cmp++; if (cnt(0) !== 4'd0) begin n_bad++; $display("FAIL clr_vs_event: got %0d want 0", cnt(0)); end
    ClrMask = 6'b000001; En = 1'b1; Sel = 3'd4;
    tick();
    ClrMask = '0; En = 1'b0;
    n_cmp++; if (cnt(4) !== 4'd1 || cnt(0) !== 4'd0) begin n_bad++; $display("FAIL other_ch_proceeds: got c4=%0d c0=%0d want 1 0", cnt(4), cnt(0)); end
    CfgWe = 1'b1; CfgCh = 3'd4; CfgDiv = 4'd0; CfgMode = 1'b0; En = 1'b1; Sel = 3'd4;
    tick();
    CfgWe = 1'b0; En = 1'b0;
    n_cmp++; if (cnt(4) !== 4'd1) begin n_bad++; $display("FAIL cfg_vs_event: got %0d want 1", cnt(4)); end
    $display("test_clr_priority done");
  endtask

  task automatic test_read;
    events(0, 9);
    RdReq = 1'b1; RdCh = 3'd0; RdClr = 1'b1;
    tick();
    RdReq = 1'b0; RdClr = 1'b0;
    $display("read ch0 clr: valid=%b data=%0d", RdValid, RdData);
    n_cmp++; if (RdValid !== 1'b1 || RdData !== 4'd9) begin n_bad++; $display("FAIL rdclr_data: got %b/%0d want 1/9", RdValid, RdData); end
    n_cmp++; if (cnt(0) !== 4'd0) begin n_bad++; $display("FAIL rdclr_count: got %0d want 0", cnt(0)); end
    tick();
    n_cmp++; if (RdValid !== 1'b0 || RdData !== 4'd9) begin n_bad++; $display("FAIL rd_idle_hold: got %b/%0d want 0/9", RdValid, RdData); end
    RdReq = 1'b1; RdCh = 3'd6; RdClr = 1'b1;
    tick();
    RdReq = 1'b0; RdClr = 1'b0;
    $display("read ch6: valid=%b data=%0d", RdValid, RdData);
    n_cmp++; if (RdValid !== 1'b1 || RdData !== 4'd0) begin n_bad++; $display("FAIL rd_out_of_range: got %b/%0d want 1/0", RdValid, RdData); end
    n_cmp++; if (cnt(1) !== 4'd2 || cnt(3) !== 4'd15 || cnt(4) !== 4'd1) begin
      n_bad++; $display("FAIL rd_oor_state: got c1=%0d c3=%0d c4=%0d want 2 15 1", cnt(1), cnt(3), cnt(4));
    end
    $display("test_read done");
  endtask

  task automatic test_back_to_back;
    RdReq = 1'b1; RdClr = 1'b0; RdCh = 3'd4;
    tick();
    n_cmp++; if (RdValid !== 1'b1 || RdData !== 4'd1) begin n_bad++; $display("FAIL b2b_0: got %b/%0d want 1/1", RdValid, RdData); end
    RdCh = 3'd1;
    tick();
    n_cmp++; if (RdValid !== 1'b1 || RdData !== 4'd2) begin n_bad++; $display("FAIL b2b_1: got %b/%0d want 1/2", RdValid, RdData); end
    RdCh = 3'd4; RdClr = 1'b1;
    tick();
    RdReq = 1'b0; RdClr = 1'b0;
    n_cmp++; if (RdValid !== 1'b1 || RdData !== 4'd1 || cnt(4) !== 4'd0) begin
      n_bad++; $display("FAIL b2b_2: got %b/%0d c4=%0d want 1/1 c4=0", RdValid, RdData, cnt(4));
    end
    tick();
    n_cmp++; if (RdValid !== 1'b0 || cnt(1) !== 4'd2) begin n_bad++; $display("FAIL b2b_idle: got %b c1=%0d want 0 c1=2", RdValid, cnt(1)); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midstream;
    events(2, 16);
    n_cmp++; if (Ovf[2] !== 1'b1) begin n_bad++; $display("FAIL pre_reset_ovf: got %b want 1", Ovf[2]); end
    En = 1'b1; Sel = 3'd1; RdReq = 1'b1; RdCh = 3'd1; Reset = 1'b1;
    tick();
    Reset = 1'b0; RdReq = 1'b0; En = 1'b0;
    n_cmp++; if (Count !== '0 || Ovf !== '0 || AnyOvf !== 1'b0) begin
      n_bad++; $display("FAIL midreset_state: got %h/%b/%b want 0/0/0", Count, Ovf, AnyOvf);
    end
    n_cmp++; if (RdValid !== 1'b0 || RdData !== '0) begin n_bad++; $display("FAIL midreset_rd: got %b/%0d want 0/0", RdValid, RdData); end
    events(1, 1);
    n_cmp++; if (cnt(1) !== 4'd1) begin n_bad++; $display("FAIL div_reset: got %0d want 1", cnt(1)); end
    events(3, 16);
    n_cmp++; if (cnt(3) !== 4'd0 || Ovf[3] !== 1'b1) begin n_bad++; $display("FAIL mode_reset: got %0d/%b want 0/1", cnt(3), Ovf[3]); end
    $display("test_reset_midstream done");
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Sel = '0; CfgWe = 1'b0; CfgCh = '0; CfgDiv = '0;
    CfgMode = 1'b0; ClrMask = '0; RdReq = 1'b0; RdCh = '0; RdClr = 1'b0;
    test_reset();
    test_basic_count();
    test_prescale();
    test_overflow();
    test_clr_priority();
    test_read();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
